act_unit: RTL

Pipelined piecewise-linear activation stage sitting directly downstream of the neural-unit array. Each accepted transfer carries one Q4.12 accumulator result per neural unit. Each lane is mapped through a selectable activation function: bypass, ReLU, or a 64-segment linear LUT evaluating y = a·x + b. The saturated Q4.12 vector is then emitted toward XY memory write-back, with a valid/ready handshake on both sides.

---
 rtl/act_unit.sv | 195 +++++++++++++++++++
 1 files changed

// File: rtl/act_unit.sv
`default_nettype none
// ============================================================================
// Module   : act_unit
// Purpose  : Pipelined piecewise-linear activation stage. Each transfer
//            carries LANES signed Q4.12 values. Every lane is mapped through
//            bypass, ReLU, a 64-segment linear LUT (y = a*x + b), or the LUT
//            followed by ReLU. The result is saturated to Q4.12.
//            Three register stages (S1 lookup, S2 multiply, S3 add/saturate)
//            advance together under a single enable, so backpressure from the
//            output freezes the whole pipe.
// Ports    : clk, rst        - clock, asynchronous active-high reset
//            in_valid/ready  - input handshake, in_ready = pipe can advance
//            in_data, in_sel - packed lanes and activation select
//            out_valid/ready - output handshake
//            out_data        - activated lanes, same packing as in_data
//            lut_we/addr/wdata - LUT write port, {a[31:16], b[15:0]}
// Revision : 1.0 - initial release
// ============================================================================
module act_unit #(
    parameter int LANES     = 4,
    parameter int Q_INT     = 4,
    parameter int Q_FRAC    = 12,
    parameter int Q_SIZE    = 16,
    parameter int LUT_DEPTH = 6,
    parameter int LUT_SIZE  = 32,
    parameter int MASK_SIZE = 2
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic [LANES*Q_SIZE-1:0]   in_data,
    input  logic [MASK_SIZE-1:0]      in_sel,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [LANES*Q_SIZE-1:0]   out_data,
    input  logic                      lut_we,
    input  logic [LUT_DEPTH-1:0]      lut_addr,
    input  logic [LUT_SIZE-1:0]       lut_wdata
);

    // Lane word width, product width, shifted-product width, sum width.
    localparam int c_W           = Q_INT + Q_FRAC;
    localparam int c_PW          = 2 * c_W;
    localparam int c_QW          = c_PW - Q_FRAC;
    localparam int c_SW          = c_QW + 1;
    localparam int c_LUT_ENTRIES = 2 ** LUT_DEPTH;

    localparam logic [MASK_SIZE-1:0] c_SEL_BYPASS = MASK_SIZE'(0);
    localparam logic [MASK_SIZE-1:0] c_SEL_RELU   = MASK_SIZE'(1);
    localparam logic [MASK_SIZE-1:0] c_SEL_LUT    = MASK_SIZE'(2);

    // ------------------------------------------------------------------------
    // Pipeline control. Every stage moves when the output slot is empty or
    // being drained this cycle; otherwise everything holds in place.
    // ------------------------------------------------------------------------
    logic                 w_en;
    logic                 r_s1_valid;
    logic                 r_s2_valid;
    logic                 r_out_valid;
    logic [MASK_SIZE-1:0] r_s1_sel;
    logic [MASK_SIZE-1:0] r_s2_sel;

    assign w_en      = !r_out_valid || out_ready;
    assign in_ready  = w_en;
    assign out_valid = r_out_valid;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_s1_valid  <= 1'b0;
            r_s2_valid  <= 1'b0;
            r_out_valid <= 1'b0;
            r_s1_sel    <= '0;
            r_s2_sel    <= '0;
        end else if (w_en) begin
            r_s1_valid  <= in_valid;
            r_s2_valid  <= r_s1_valid;
            r_out_valid <= r_s2_valid;
            if (in_valid) begin
                r_s1_sel <= in_sel;
            end
            if (r_s1_valid) begin
                r_s2_sel <= r_s1_sel;
            end
        end
    end

    // ------------------------------------------------------------------------
    // Coefficient LUT. Writes land at the edge; reads are combinational, so a
    // lookup captured at the same edge as a write still sees the old entry.
    // ------------------------------------------------------------------------
    logic [LUT_SIZE-1:0] r_lut [c_LUT_ENTRIES];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int k = 0; k < c_LUT_ENTRIES; k++) begin
                r_lut[k] <= '0;
            end
        end else if (lut_we) begin
            r_lut[lut_addr] <= lut_wdata;
        end
    end

    // ------------------------------------------------------------------------
    // Per-lane datapath
    // ------------------------------------------------------------------------
    generate
        for (genvar i = 0; i < LANES; i++) begin : g_lane
            logic        [c_W-1:0]       w_x_in;
            logic        [LUT_DEPTH-1:0] w_idx;
            logic        [LUT_SIZE-1:0]  w_entry;

            logic signed [c_W-1:0]       r_s1_x;
            logic signed [c_W-1:0]       r_s1_a;
            logic signed [c_W-1:0]       r_s1_b;

            logic signed [c_PW-1:0]      w_prod;
            logic                        w_unused_prod_lsbs;

            logic signed [c_QW-1:0]      r_s2_q;
            logic signed [c_W-1:0]       r_s2_b;
            logic signed [c_W-1:0]       r_s2_x;

            logic signed [c_SW-1:0]      w_sum;
            logic                        w_fits;
            logic        [c_W-1:0]       w_sat;
            logic        [c_W-1:0]       w_r;
            logic        [c_W-1:0]       r_out;

            assign w_x_in = in_data[i*Q_SIZE +: Q_SIZE];

            // Segment = offset-binary of the top bits: flipping the sign bit
            // maps [-8, 8) onto 0..63 in steps of 0.25.
            assign w_idx   = {~w_x_in[c_W-1], w_x_in[c_W-2 -: LUT_DEPTH-1]};
            assign w_entry = r_lut[w_idx];

            // Taking the upper bits of the product is an arithmetic right
            // shift by Q_FRAC (floor). |a*x| <= 2^30 so 20 bits always hold it.
            assign w_prod             = r_s1_a * r_s1_x;
            assign w_unused_prod_lsbs = ^w_prod[Q_FRAC-1:0];

            assign w_sum = {r_s2_q[c_QW-1], r_s2_q}
                         + {{(c_SW-c_W){r_s2_b[c_W-1]}}, r_s2_b};

            // The sum fits in c_W bits when all bits above the result's sign
            // bit agree with it.
            assign w_fits = (&w_sum[c_SW-1:c_W-1]) | ~(|w_sum[c_SW-1:c_W-1]);
            assign w_sat  = w_fits ? w_sum[c_W-1:0]
                          : (w_sum[c_SW-1] ? {1'b1, {(c_W-1){1'b0}}}
                                           : {1'b0, {(c_W-1){1'b1}}});

            always_comb begin
                w_r = r_s2_x;
                case (r_s2_sel)
                    c_SEL_BYPASS: w_r = r_s2_x;
                    c_SEL_RELU:   w_r = r_s2_x[c_W-1] ? '0 : r_s2_x;
                    c_SEL_LUT:    w_r = w_sat;
                    default:      w_r = w_sat[c_W-1] ? '0 : w_sat;
                endcase
            end

            // Data registers only load when their incoming slot is valid so
            // bubbles do not disturb the held values.
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    r_s1_x <= '0;
                    r_s1_a <= '0;
                    r_s1_b <= '0;
                    r_s2_q <= '0;
                    r_s2_b <= '0;
                    r_s2_x <= '0;
                    r_out  <= '0;
                end else if (w_en) begin
                    if (in_valid) begin
                        r_s1_x <= w_x_in;
                        r_s1_a <= w_entry[LUT_SIZE-1 -: c_W];
                        r_s1_b <= w_entry[c_W-1:0];
                    end
                    if (r_s1_valid) begin
                        r_s2_q <= w_prod[c_PW-1:Q_FRAC];
                        r_s2_b <= r_s1_b;
                        r_s2_x <= r_s1_x;
                    end
                    if (r_s2_valid) begin
                        r_out <= w_r;
                    end
                end
            end

            assign out_data[i*Q_SIZE +: Q_SIZE] = r_out;
        end
    endgenerate

endmodule
`default_nettype wire
